// File: rtl/lfsr_step.sv
// lfsr_step: one-call LFSR / CRC engine. Advances an LFSR_WIDTH-bit state by
// DATA_WIDTH serial input bits and returns the new state plus the
// scrambled/descrambled data bits. Galois and Fibonacci forms, additive or
// feed-forward (descrambler) operation, optional bit reflection, and an
// optional output register.
module lfsr_step #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO",
  parameter bit                    REG_OUTPUT        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int W  = LFSR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int N  = W + DW;
  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  // Bad configuration strings stop elaboration rather than silently
  // building the wrong polynomial form.
  if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : gen_bad_config
    $error("lfsr_step: LFSR_CONFIG must be FIBONACCI or GALOIS");
  end
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : gen_bad_style
    $error("lfsr_step: STYLE must be AUTO, LOOP or REDUCTION");
  end

  // Reference serial model. Input and result are packed as {state, data}.
  // Every style is derived from this one function, so they cannot diverge.
  function automatic logic [N-1:0] lfsr_core(input logic [N-1:0] vec);
    logic [W-1:0]  s;
    logic [W-1:0]  s_tmp;
    logic [DW-1:0] d;
    logic [DW-1:0] d_tmp;
    logic [DW-1:0] o;
    logic [DW-1:0] o_tmp;
    logic          fb;
    logic          tap;
    s = vec[N-1:DW];
    d = vec[DW-1:0];
    o = '0;
    fb = 1'b0;
    tap = 1'b0;
    // Reflected mode: LSB-first on the wire, so mirror state and data.
    if (REVERSE) begin
      s_tmp = s;
      d_tmp = d;
      for (int k = 0; k < W; k++) s[k] = s_tmp[W-1-k];
      for (int k = 0; k < DW; k++) d[k] = d_tmp[DW-1-k];
    end
    for (int i = DW - 1; i >= 0; i--) begin
      if (IS_GALOIS) begin
        // Feed-forward feeds the raw input bit back instead of msb^input.
        fb = LFSR_FEED_FORWARD ? d[i] : (s[W-1] ^ d[i]);
        o[i] = s[W-1] ^ d[i];
        s = (s << 1) ^ (LFSR_POLY & {W{fb}});
      end else begin
        tap = s[W-1];
        for (int j = 1; j < W; j++) tap = tap ^ (s[j-1] & LFSR_POLY[j]);
        o[i] = tap ^ d[i];
        s = s << 1;
        s[0] = LFSR_FEED_FORWARD ? d[i] : (tap ^ d[i]);
      end
    end
    if (REVERSE) begin
      s_tmp = s;
      o_tmp = o;
      for (int k = 0; k < W; k++) s[k] = s_tmp[W-1-k];
      for (int k = 0; k < DW; k++) o[k] = o_tmp[DW-1-k];
    end
    return {s, o};
  endfunction

  // The transform is linear over GF(2): column k of the matrix is the
  // response to the k-th unit input vector. Row b selects which input bits
  // are XORed into output bit b.
  function automatic logic [N-1:0][N-1:0] build_matrix();
    logic [N-1:0][N-1:0] m;
    logic [N-1:0]        e;
    logic [N-1:0]        r;
    m = '0;
    for (int k = 0; k < N; k++) begin
      e = '0;
      e[k] = 1'b1;
      r = lfsr_core(e);
      for (int b = 0; b < N; b++) m[b][k] = r[b];
    end
    return m;
  endfunction

  logic [N-1:0] in_vec;
  logic [N-1:0] comb_vec;

  assign in_vec = {state_in, data_in};

  if (STYLE == "LOOP") begin : gen_loop
    // Unrolled serial loop evaluated directly on the live inputs.
    always_comb begin
      comb_vec = lfsr_core(in_vec);
    end
  end else begin : gen_reduction
    localparam logic [N-1:0][N-1:0] XMAT = build_matrix();
    for (genvar b = 0; b < N; b++) begin : gen_bit
      assign comb_vec[b] = ^(in_vec & XMAT[b]);
    end
  end

  if (REG_OUTPUT) begin : gen_reg
    logic [W-1:0]  state_q;
    logic [DW-1:0] data_q;
    // Output register; reset loads the conventional all-ones LFSR seed.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= '1;
        data_q  <= '0;
      end else begin
        state_q <= comb_vec[N-1:DW];
        data_q  <= comb_vec[DW-1:0];
      end
    end
    assign state_out = state_q;
    assign data_out  = data_q;
  end else begin : gen_comb
    // Purely combinational: clock and reset have no effect here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign state_out = comb_vec[N-1:DW];
    assign data_out  = comb_vec[DW-1:0];
  end

endmodule

// File: tb/tb_lfsr_step.sv
// Bench for lfsr_step: CRC-32 (reflected, both styles), CRC-32/MPEG-2,
// PRBS31 scramble/descramble round trip, and the registered-output variant.
module tb_lfsr_step;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  dexp_q[$];

  // Reflected CRC-32, AUTO and LOOP styles share inputs.
  logic [31:0] le_state;
  logic [7:0]  le_data;
  logic [31:0] le_state_out, lp_state_out;
  logic [7:0]  le_data_out, lp_data_out;
  // Non-reflected CRC-32 (MPEG-2).
  logic [31:0] be_state;
  logic [7:0]  be_data;
  logic [31:0] be_state_out;
  logic [7:0]  be_data_out;
  // PRBS31 scrambler feeding a descrambler.
  logic [30:0] sc_state, ds_state;
  logic [7:0]  sc_data;
  logic [30:0] sc_state_out, ds_state_out;
  logic [7:0]  sc_data_out, ds_data_out;
  // Registered reflected CRC-32.
  logic [31:0] rg_state;
  logic [7:0]  rg_data;
  logic [31:0] rg_state_out;
  logic [7:0]  rg_data_out;

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8), .STYLE("AUTO"),
    .REG_OUTPUT(1'b0)) u_le (.clk(clk), .rst(rst), .data_in(le_data),
    .state_in(le_state), .data_out(le_data_out), .state_out(le_state_out));

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8), .STYLE("LOOP"),
    .REG_OUTPUT(1'b0)) u_lp (.clk(clk), .rst(rst), .data_in(le_data),
    .state_in(le_state), .data_out(lp_data_out), .state_out(lp_state_out));

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b0), .DATA_WIDTH(8), .STYLE("REDUCTION"),
    .REG_OUTPUT(1'b0)) u_be (.clk(clk), .rst(rst), .data_in(be_data),
    .state_in(be_state), .data_out(be_data_out), .state_out(be_state_out));

  lfsr_step #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b0), .DATA_WIDTH(8), .STYLE("AUTO"),
    .REG_OUTPUT(1'b0)) u_sc (.clk(clk), .rst(rst), .data_in(sc_data),
    .state_in(sc_state), .data_out(sc_data_out), .state_out(sc_state_out));

  lfsr_step #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(1'b1), .REVERSE(1'b0), .DATA_WIDTH(8), .STYLE("LOOP"),
    .REG_OUTPUT(1'b0)) u_ds (.clk(clk), .rst(rst), .data_in(sc_data_out),
    .state_in(ds_state), .data_out(ds_data_out), .state_out(ds_state_out));

  lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8), .STYLE("AUTO"),
    .REG_OUTPUT(1'b1)) u_rg (.clk(clk), .rst(rst), .data_in(rg_data),
    .state_in(rg_state), .data_out(rg_data_out), .state_out(rg_state_out));

  // Textbook reflected CRC-32 bit loop (poly EDB88320, LSB first).
  function automatic logic [39:0] crc_le_model(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] o;
    logic fb;
    o = '0;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      o[k] = fb;
      c = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return {c, o};
  endfunction

  // MSB-first CRC-32 bit loop (poly 04C11DB7).
  function automatic logic [39:0] crc_be_model(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] o;
    logic fb;
    o = '0;
    for (int k = 7; k >= 0; k--) begin
      fb = c[31] ^ b[k];
      o[k] = fb;
      c = (c << 1) ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return {c, o};
  endfunction

  // x^31 + x^28 + 1 additive scrambler, MSB first.
  function automatic logic [38:0] prbs_model(input logic [30:0] s, input logic [7:0] d);
    logic [7:0] o;
    logic tap;
    o = '0;
    for (int i = 7; i >= 0; i--) begin
      tap = s[30] ^ s[27];
      o[i] = tap ^ d[i];
      s = {s[29:0], tap ^ d[i]};
    end
    return {s, o};
  endfunction

  task automatic test_reset();
    logic [31:0] es;
    logic [7:0]  ed;
    @(negedge clk);
    rst = 1'b1;
    rg_state = 32'h12345678;
    rg_data = 8'hA5;
    exp_q.push_back(32'hFFFFFFFF);
    dexp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    es = exp_q.pop_front();
    ed = dexp_q.pop_front();
    tests_run++;
    if (rg_state_out !== es) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", rg_state_out, es);
    end
    tests_run++;
    if (rg_data_out !== ed) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected %h", rg_data_out, ed);
    end
  endtask

  task automatic test_crc_single();
    logic [39:0] m;
    logic [31:0] es;
    logic [7:0]  ed;
    le_state = 32'hFFFFFFFF;
    le_data = 8'h00;
    m = crc_le_model(le_state, le_data);
    exp_q.push_back(32'h2DFD1072);
    dexp_q.push_back(m[7:0]);
    #1;
    es = exp_q.pop_front();
    ed = dexp_q.pop_front();
    tests_run++;
    if (le_state_out !== es) begin
      tests_failed++;
      $display("FAIL crc_single_auto_state: got %h expected %h", le_state_out, es);
    end
    tests_run++;
    if (lp_state_out !== es) begin
      tests_failed++;
      $display("FAIL crc_single_loop_state: got %h expected %h", lp_state_out, es);
    end
    tests_run++;
    if (le_data_out !== ed || lp_data_out !== ed) begin
      tests_failed++;
      $display("FAIL crc_single_data: got %h/%h expected %h", le_data_out, lp_data_out, ed);
    end
  endtask

  task automatic test_linearity();
    le_state = 32'h0;
    le_data = 8'h00;
    be_state = 32'h0;
    be_data = 8'h00;
    #1;
    tests_run++;
    if (le_state_out !== 32'h0 || lp_state_out !== 32'h0 || be_state_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_state: got %h/%h/%h expected 00000000", le_state_out, lp_state_out, be_state_out);
    end
    tests_run++;
    if (le_data_out !== 8'h0 || lp_data_out !== 8'h0 || be_data_out !== 8'h0) begin
      tests_failed++;
      $display("FAIL zero_data: got %h/%h/%h expected 00", le_data_out, lp_data_out, be_data_out);
    end
  endtask

  task automatic test_check_string();
    logic [31:0] c;
    logic [39:0] m;
    logic [31:0] es;
    logic [7:0]  ed;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      le_state = c;
      le_data = 8'(8'h31 + i);
      m = crc_le_model(c, le_data);
      exp_q.push_back(m[39:8]);
      dexp_q.push_back(m[7:0]);
      c = m[39:8];
      #1;
      es = exp_q.pop_front();
      ed = dexp_q.pop_front();
      tests_run++;
      if (le_state_out !== es || lp_state_out !== es) begin
        tests_failed++;
        $display("FAIL crc_le_step%0d_state: got %h/%h expected %h", i, le_state_out, lp_state_out, es);
      end
      tests_run++;
      if (le_data_out !== ed || lp_data_out !== ed) begin
        tests_failed++;
        $display("FAIL crc_le_step%0d_data: got %h/%h expected %h", i, le_data_out, lp_data_out, ed);
      end
    end
    tests_run++;
    if (le_state_out !== 32'h340BC6D9) begin
      tests_failed++;
      $display("FAIL crc_le_check: got %h expected 340bc6d9", le_state_out);
    end
  endtask

  task automatic test_mpeg2();
    logic [31:0] c;
    logic [39:0] m;
    logic [31:0] es;
    logic [7:0]  ed;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      be_state = c;
      be_data = 8'(8'h31 + i);
      m = crc_be_model(c, be_data);
      exp_q.push_back(m[39:8]);
      dexp_q.push_back(m[7:0]);
      c = m[39:8];
      #1;
      es = exp_q.pop_front();
      ed = dexp_q.pop_front();
      tests_run++;
      if (be_state_out !== es || be_data_out !== ed) begin
        tests_failed++;
        $display("FAIL crc_be_step%0d: got %h/%h expected %h/%h", i, be_state_out, be_data_out, es, ed);
      end
    end
    tests_run++;
    if (be_state_out !== 32'h0376E6E7) begin
      tests_failed++;
      $display("FAIL crc_be_check: got %h expected 0376e6e7", be_state_out);
    end
  endtask

  task automatic test_prbs();
    logic [30:0] s;
    logic [38:0] m;
    logic [7:0]  plain;
    logic [31:0] es;
    logic [7:0]  ed;
    s = 31'($urandom) | 31'h1;
    for (int i = 0; i < 32; i++) begin
      plain = 8'($urandom_range(0, 255));
      sc_state = s;
      ds_state = s;
      sc_data = plain;
      m = prbs_model(s, plain);
      exp_q.push_back({1'b0, m[38:8]});
      dexp_q.push_back(m[7:0]);
      s = m[38:8];
      #1;
      es = exp_q.pop_front();
      ed = dexp_q.pop_front();
      tests_run++;
      if (sc_data_out !== ed || {1'b0, sc_state_out} !== es) begin
        tests_failed++;
        $display("FAIL prbs_scramble%0d: got %h/%h expected %h/%h", i, sc_data_out, sc_state_out, ed, es[30:0]);
      end
      tests_run++;
      if (ds_data_out !== plain || {1'b0, ds_state_out} !== es) begin
        tests_failed++;
        $display("FAIL prbs_descramble%0d: got %h/%h expected %h/%h", i, ds_data_out, ds_state_out, plain, es[30:0]);
      end
    end
  endtask

  // Registered path: new inputs every cycle, each result one cycle later.
  task automatic test_back_to_back();
    logic [31:0] c;
    logic [39:0] m;
    logic [31:0] es;
    logic [7:0]  ed;
    @(negedge clk);
    rst = 1'b0;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      rg_state = c;
      rg_data = 8'(8'h31 + i);
      m = crc_le_model(c, rg_data);
      exp_q.push_back(m[39:8]);
      dexp_q.push_back(m[7:0]);
      c = m[39:8];
      @(posedge clk);
      #1;
      es = exp_q.pop_front();
      ed = dexp_q.pop_front();
      tests_run++;
      if (rg_state_out !== es || rg_data_out !== ed) begin
        tests_failed++;
        $display("FAIL reg_step%0d: got %h/%h expected %h/%h", i, rg_state_out, rg_data_out, es, ed);
      end
    end
    tests_run++;
    if (rg_state_out !== 32'h340BC6D9) begin
      tests_failed++;
      $display("FAIL reg_check: got %h expected 340bc6d9", rg_state_out);
    end
  endtask

  // Reset asserted mid-stream must win over the computed value.
  task automatic test_mid_reset();
    logic [39:0] m;
    logic [31:0] es;
    logic [7:0]  ed;
    rst = 1'b1;
    rg_state = 32'hDEADBEEF;
    rg_data = 8'h5A;
    exp_q.push_back(32'hFFFFFFFF);
    dexp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    es = exp_q.pop_front();
    ed = dexp_q.pop_front();
    tests_run++;
    if (rg_state_out !== es || rg_data_out !== ed) begin
      tests_failed++;
      $display("FAIL mid_reset: got %h/%h expected %h/%h", rg_state_out, rg_data_out, es, ed);
    end
    rst = 1'b0;
    rg_state = 32'hDEADBEEF;
    rg_data = 8'h5A;
    m = crc_le_model(rg_state, rg_data);
    exp_q.push_back(m[39:8]);
    dexp_q.push_back(m[7:0]);
    @(posedge clk);
    #1;
    es = exp_q.pop_front();
    ed = dexp_q.pop_front();
    tests_run++;
    if (rg_state_out !== es || rg_data_out !== ed) begin
      tests_failed++;
      $display("FAIL after_reset: got %h/%h expected %h/%h", rg_state_out, rg_data_out, es, ed);
    end
    tests_run++;
    if (exp_q.size() != 0 || dexp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp_q.size(), dexp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    le_state = '0; le_data = '0;
    be_state = '0; be_data = '0;
    sc_state = '0; ds_state = '0; sc_data = '0;
    rg_state = '0; rg_data = '0;
    test_reset();
    test_crc_single();
    test_linearity();
    test_check_string();
    test_mpeg2();
    test_prbs();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
